recfg_result_drain: RTL and testbench

Read-side companion of the 16×16 reconfigurable systolic array. On each tile-done pulse it snapshots the array's vector or matrix result and streams it out as row beats on a valid/ready write interface toward the result SRAM / writeback path. It generates row addresses and reports busy and overflow status. The tile sequencer uses `busy` to hold off the next tile.

---
 rtl/recfg_pkg.sv | 16 +
 rtl/recfg_result_drain.sv | 126 ++++++++++++
 tb/tb_recfg_result_drain.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/recfg_pkg.sv
// Shared types for the systolic-array result drain: FSM states, row counter
// width and the shape encoding used on out_shape_flag.
package recfg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    localparam int TILE_DIM  = 16;
    localparam int ROW_CNT_W = $clog2(TILE_DIM);

    localparam logic SHAPE_VEC = 1'b0;
    localparam logic SHAPE_MAT = 1'b1;

endpackage

// File: rtl/recfg_result_drain.sv
// Snapshots the array result on done_tile and streams it as row beats with
// row addresses over valid/ready; reports busy, dropped-tile overflow and drain count.
module recfg_result_drain
    import recfg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int ROW_STRIDE = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   done_tile,
    input  logic                                                   out_shape_flag,
    input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]                   result_out_vec,
    input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]    result_out_mat,
    input  logic [ADDR_WIDTH-1:0]                                  tile_base_addr,
    output logic                                                   m_valid,
    input  logic                                                   m_ready,
    output logic [TILE_SIZE*DATA_WIDTH-1:0]                        m_data,
    output logic [ADDR_WIDTH-1:0]                                  m_addr,
    output logic                                                   m_last,
    output logic                                                   busy,
    output logic                                                   overflow_err,
    output logic [15:0]                                            tiles_drained
);

    localparam int RCW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ROW_STRIDE);

    typedef logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_t;

    drain_state_t          state_q, state_d;
    tile_t                 snap_q, snap_d;
    logic [RCW-1:0]        row_cnt_q, row_cnt_d;
    logic [RCW-1:0]        last_row_q, last_row_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           tiles_q, tiles_d;

    logic xfer, final_xfer, capture;

    assign xfer       = valid_q & m_ready;
    assign final_xfer = xfer & last_q;
    // A new tile is only accepted when nothing is in flight after this edge.
    assign capture    = done_tile & ((state_q == IDLE) | final_xfer);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        row_cnt_d  = row_cnt_q;
        last_row_d = last_row_q;
        base_d     = base_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q | (done_tile & ~capture);
        tiles_d    = tiles_q;

        if (final_xfer) begin
            tiles_d = tiles_q + 16'd1;
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
        end else if (xfer) begin
            row_cnt_d = row_cnt_q + 1'b1;
            last_d    = ((row_cnt_q + 1'b1) == last_row_q);
        end

        if (capture) begin
            if (out_shape_flag == SHAPE_MAT) begin
                snap_d     = result_out_mat;
                last_row_d = RCW'(TILE_SIZE - 1);
                last_d     = (TILE_SIZE == 1);
            end else begin
                snap_d[0]  = result_out_vec;
                last_row_d = '0;
                last_d     = 1'b1;
            end
            base_d    = tile_base_addr;
            row_cnt_d = '0;
            state_d   = STREAM;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            row_cnt_q  <= '0;
            last_row_q <= '0;
            base_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tiles_q    <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            row_cnt_q  <= row_cnt_d;
            last_row_q <= last_row_d;
            base_q     <= base_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            tiles_q    <= tiles_d;
        end
    end

    assign m_valid       = valid_q;
    assign m_last        = last_q;
    assign busy          = busy_q;
    assign overflow_err  = ovf_q;
    assign tiles_drained = tiles_q;
    assign m_data        = snap_q[row_cnt_q];
    assign m_addr        = base_q + ADDR_WIDTH'(row_cnt_q) * STRIDE;

endmodule

// File: tb/tb_recfg_result_drain.sv
// Scoreboard bench for recfg_result_drain: expected beats are queued when a
// tile is driven and compared as the DUT hands each beat over.
module tb_recfg_result_drain;

    typedef struct {
        logic [255:0] d;
        logic [15:0]  a;
        logic         l;
    } beat_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        done_tile;
    logic                        out_shape_flag;
    logic [15:0][15:0]           vec_in;
    logic [15:0][15:0][15:0]     mat_in;
    logic [15:0]                 base_in;
    logic                        m_valid;
    logic                        m_ready;
    logic [255:0]                m_data;
    logic [15:0]                 m_addr;
    logic                        m_last;
    logic                        busy;
    logic                        overflow_err;
    logic [15:0]                 tiles_drained;

    int    checks = 0;
    int    failures = 0;
    int    beats = 0;
    beat_t sb[$];

    recfg_result_drain #(
        .DATA_WIDTH(16), .TILE_SIZE(16), .ADDR_WIDTH(16), .ROW_STRIDE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .done_tile(done_tile),
        .out_shape_flag(out_shape_flag), .result_out_vec(vec_in),
        .result_out_mat(mat_in), .tile_base_addr(base_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_addr(m_addr), .m_last(m_last), .busy(busy),
        .overflow_err(overflow_err), .tiles_drained(tiles_drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: scoreboard compare on transfers, stability check across stalls.
    logic         stalled = 1'b0;
    logic [255:0] pd;
    logic [15:0]  pa;
    logic         pl;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (m_valid) begin
            if (stalled) begin
                chk("stall_data", m_data, pd);
                chk("stall_addr", {240'd0, m_addr}, {240'd0, pa});
                chk("stall_last", {255'd0, m_last}, {255'd0, pl});
            end
            if (m_ready) begin
                stalled = 1'b0;
                beats++;
                if (sb.size() == 0) begin
                    chk("unexp_beat", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_addr", {240'd0, m_addr}, {240'd0, e.a});
                    chk("beat_last", {255'd0, m_last}, {255'd0, e.l});
                end
            end else begin
                stalled = 1'b1;
                pd = m_data;
                pa = m_addr;
                pl = m_last;
            end
        end else if (stalled) begin
            chk("valid_drop", {255'd0, m_valid}, 256'd1);
            stalled = 1'b0;
        end
    end

    // Sets done_tile and tile inputs for the current cycle; queues expected beats if asked.
    task automatic drive_tile(input logic shape, input int seed, input logic [15:0] base,
                              input bit expect_it);
        beat_t b;
        done_tile      = 1'b1;
        out_shape_flag = shape;
        base_in        = base;
        for (int r = 0; r < 16; r++) begin
            vec_in[r] = 16'(seed * 1000 + r + 1);
            for (int c = 0; c < 16; c++)
                mat_in[r][c] = shape ? 16'(seed * 1000 + r * 16 + c) : 16'hDEAD;
        end
        if (expect_it) begin
            for (int r = 0; r < (shape ? 16 : 1); r++) begin
                for (int c = 0; c < 16; c++)
                    b.d[c*16 +: 16] = shape ? 16'(seed * 1000 + r * 16 + c)
                                            : 16'(seed * 1000 + c + 1);
                b.a = 16'(base + r * 16);
                b.l = shape ? (r == 15) : 1'b1;
                sb.push_back(b);
            end
        end
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 256'(sb.size()), 256'd0);
    endtask

    initial begin
        int b0;
        rst_n = 1'b0; done_tile = 1'b0; out_shape_flag = 1'b0;
        vec_in = '0; mat_in = '0; base_in = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {255'd0, m_valid}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_last", {255'd0, m_last}, 256'd0);
        chk("rst_ovf", {255'd0, overflow_err}, 256'd0);
        chk("rst_data", m_data, 256'd0);
        chk("rst_addr", {240'd0, m_addr}, 256'd0);
        chk("rst_tiles", {240'd0, tiles_drained}, 256'd0);
        rst_n = 1'b1;

        // Vector drain with one-cycle latency
        @(posedge clk); #1;
        drive_tile(1'b0, 0, 16'h0100, 1'b1);
        @(negedge clk);
        chk("vec_lat0", {255'd0, m_valid}, 256'd0);
        @(posedge clk); #1;
        done_tile = 1'b0;
        @(negedge clk);
        chk("vec_valid", {255'd0, m_valid}, 256'd1);
        chk("vec_busy", {255'd0, busy}, 256'd1);
        chk("vec_e0", {240'd0, m_data[15:0]}, 256'd1);
        chk("vec_e15", {240'd0, m_data[255:240]}, 256'd16);
        @(negedge clk);
        chk("vec_idle", {255'd0, m_valid}, 256'd0);
        chk("vec_tiles", {240'd0, tiles_drained}, 256'd1);

        // Matrix drain, m_ready held high: 16 consecutive beats
        @(posedge clk); #1;
        drive_tile(1'b1, 0, 16'h0200, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("mat_consec", {255'd0, m_valid}, 256'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mat_busy_low", {255'd0, busy}, 256'd0);
        chk("mat_valid_low", {255'd0, m_valid}, 256'd0);
        chk("mat_tiles", {240'd0, tiles_drained}, 256'd2);
        chk("mat_sb_empty", 256'(sb.size()), 256'd0);

        // Backpressure: ready pattern 1,0,0 repeating
        @(posedge clk); #1;
        b0 = beats;
        drive_tile(1'b1, 1, 16'h1000, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        for (int k = 0; k < 150 && sb.size() != 0; k++) begin
            m_ready = (k % 3 == 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_beats", 256'(beats - b0), 256'd16);
        chk("bp_sb_empty", 256'(sb.size()), 256'd0);
        chk("bp_tiles", {240'd0, tiles_drained}, 256'd3);

        // Back-to-back: second done_tile lands on the final handshake of a vector tile
        @(posedge clk); #1;
        drive_tile(1'b0, 2, 16'h2000, 1'b1);
        @(posedge clk); #1;
        drive_tile(1'b1, 3, 16'hFF80, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        @(negedge clk);
        chk("b2b_no_bubble", {255'd0, m_valid}, 256'd1);
        chk("b2b_row0_addr", {240'd0, m_addr}, 256'hFF80);
        chk("b2b_ovf", {255'd0, overflow_err}, 256'd0);
        wait_drain(60);
        @(negedge clk);
        chk("b2b_tiles", {240'd0, tiles_drained}, 256'd5);
        chk("b2b_ovf_end", {255'd0, overflow_err}, 256'd0);

        // Overflow: done_tile mid-stream is dropped
        @(posedge clk); #1;
        drive_tile(1'b1, 4, 16'h0300, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive_tile(1'b1, 9, 16'h7700, 1'b0);
        @(posedge clk); #1;
        done_tile = 1'b0;
        @(negedge clk);
        chk("ovf_set", {255'd0, overflow_err}, 256'd1);
        wait_drain(60);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", {255'd0, overflow_err}, 256'd1);
        chk("ovf_tiles", {240'd0, tiles_drained}, 256'd6);
        chk("ovf_idle", {255'd0, m_valid}, 256'd0);

        // Reset mid-stream at beat 7
        @(posedge clk); #1;
        b0 = beats;
        drive_tile(1'b1, 5, 16'h0500, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        for (int n = 0; n < 40 && beats < b0 + 7; n++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mrst_valid", {255'd0, m_valid}, 256'd0);
        chk("mrst_busy", {255'd0, busy}, 256'd0);
        chk("mrst_tiles", {240'd0, tiles_drained}, 256'd0);
        chk("mrst_ovf", {255'd0, overflow_err}, 256'd0);
        chk("mrst_addr", {240'd0, m_addr}, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_tile(1'b1, 6, 16'h0400, 1'b1);
        @(posedge clk); #1;
        done_tile = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", {240'd0, m_addr}, 256'h0400);
        wait_drain(60);
        @(negedge clk);
        chk("post_rst_tiles", {240'd0, tiles_drained}, 256'd1);
        chk("post_rst_ovf", {255'd0, overflow_err}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
